arcade_input_mapper: RTL
========================

Name: arcade_input_mapper

Overview:
- Parametrised player-input front end for arcade cores.
- Merges MiSTer keyboard events and up to two joysticks into per-player arcade button words.
- Applies a selectable screen-orientation remap to the directions and generates fixed-length coin pulses.
- Sits between hps_io and the core top; replaces hand-written per-core key latches and rotation muxes.

Parameters:
- NPLAYERS, 2, player slots (1 or 2).
- COIN_LEN, 8, coin pulse length in ce_in ticks (1..255).
- AUTO_COIN, 1, when 1 a start press also requests a coin for that player.
- ACTIVE_LOW, 1, when 1 btn_out is inverted (idle = all ones).

Ports:
- clk  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- ce_in  in  1  coin-timer tick enable
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
- joystick_0  in  16  P1 joystick: [0]R [1]L [2]D [3]U [4]fire1 [5]fire2 [6]start [7]coin
- joystick_1  in  16  P2 joystick, same layout
- orient  in  2  0 none, 1 rotate CW, 2 rotate 180, 3 rotate CCW
- kbd_clear  in  1  synchronous release of all keyboard latches
- btn_out  out  NPLAYERS*8  per player p at [8p+7:8p]: [0]up [1]down [2]left [3]right [4]fire1 [5]fire2 [6]start [7]coin

Behaviour:
- Reset (async, RESET_N low): all key latches 0, coin FSMs IDLE, counters 0, primed=0, btn_out = all ones if ACTIVE_LOW else 0.
- Event detect: old_toggle register. Update rules:
  - Primed=0: the cycle after reset release loads old_toggle from ps2_key[10], sets primed=1, and decodes nothing.
  - Primed=1: an event occurs when ps2_key[10] != old_toggle; the latch for the decoded key is written with ps2_key[9].
- Key map ({ext,code}):
  - P1: E075 up, E072 down, E06B left, E074 right; 014 or 029 fire1; 011 fire2; 005 start; 02E coin.
  - P2: 02D up, 02B down, 023 left, 034 right; 01C fire1; 01B fire2; 006 start; 036 coin.
  - Unmapped codes are ignored.
  - With NPLAYERS=1, P2 codes are ignored and joystick_1 is ORed into P1.
- kbd_clear: clears all latches that cycle, with priority over a simultaneous event.
- Raw merge: raw = key latch OR joystick bits, per player.
- Rotation, applied to raw directions (U, D, L, R):
  - orient 0: identity.
  - orient 1: up=L, down=R, left=D, right=U.
  - orient 2: up=D, down=U, left=R, right=L.
  - orient 3: up=R, down=L, left=U, right=D.
  - orient may change at any cycle; the new mapping takes effect on the next output register update.
- Coin request: creq = raw coin OR (AUTO_COIN AND raw start). Coin FSM per player:
  - IDLE: on creq rising edge (creq=1, creq_d=0) load cnt=COIN_LEN and go to PULSE.
  - PULSE: coin bit = 1; decrement cnt on each ce_in. When cnt reaches 0, go to HOLD if creq=1, else IDLE. Further requests during PULSE are ignored (no extension, no queueing).
  - HOLD: coin bit = 0; go to IDLE when creq=0, so a held button produces exactly one pulse.
  - Coin bit is 1 only in PULSE. Duration is exactly COIN_LEN ce_in ticks; with ce_in held high that is COIN_LEN clk cycles.
- Output: btn_out is fully registered and XORed with ACTIVE_LOW.
- Latency:
  - Joystick change to btn_out: 1 clk.
  - ps2 toggle edge to btn_out: 2 clk.
  - creq edge to coin asserted: 2 clk.
- Reset mid-pulse aborts the pulse immediately (async).
- Simultaneous keyboard and joystick on the same bit: OR. Release of one source does not clear the other.

Test Plan:
- Reset release with ps2_key[10]=1 held: no latch changes for 4 cycles; btn_out=16'hFFFF (NPLAYERS=2, ACTIVE_LOW=1).
- Toggle ps2_key[10] with {pressed=1,ext=1,code=75}: btn_out[0]=0 two cycles later. Toggle again with pressed=0: btn_out[0]=1.
- orient=1, joystick_0[1]=1 (left): btn_out[0] (up) low after 1 clk. Switch orient to 3: up returns high and btn_out[1] (down) goes low.
- COIN_LEN=8, ce_in every 4th clk, joystick_0[7] held 200 clk: btn_out[7] low for exactly 8 ticks (~32 clk), then high with no second pulse. Release and press again: a new pulse.
- AUTO_COIN=1, key F2 pressed: P2 start bit (btn_out[14]) and P2 coin bit (btn_out[15]) both asserted; coin self-terminates after COIN_LEN ticks while start stays asserted.
- kbd_clear pulsed in the same cycle as a press event for space: all latches 0 and fire1 stays released. RESET_N asserted mid coin pulse: coin releases immediately.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Player-input front end for arcade cores. Merges MiSTer PS/2 keyboard events
//   and up to two joysticks into per-player arcade button words. It also applies
//   a screen-orientation remap to the directions and turns coin requests into
//   fixed-length pulses.
//
// Ports
//   clk        : system clock
//   RESET_N    : asynchronous active-low reset
//   ce_in      : coin-timer tick enable
//   ps2_key    : [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   joystick_0 : P1 joystick [0]R [1]L [2]D [3]U [4]fire1 [5]fire2 [6]start [7]coin
//   joystick_1 : P2 joystick, same layout (ORed into P1 when NPLAYERS == 1)
//   orient     : 0 none, 1 rotate CW, 2 rotate 180, 3 rotate CCW
//   kbd_clear  : synchronous release of every keyboard latch
//   btn_out    : per player p at [8p+7:8p]
//                [0]up [1]down [2]left [3]right [4]fire1 [5]fire2 [6]start [7]coin
module arcade_input_mapper #(
    parameter int NPLAYERS   = 2,
    parameter int COIN_LEN   = 8,
    parameter int AUTO_COIN  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic                  ce_in,
    input  logic [10:0]           ps2_key,
    input  logic [15:0]           joystick_0,
    input  logic [15:0]           joystick_1,
    input  logic [1:0]            orient,
    input  logic                  kbd_clear,
    output logic [NPLAYERS*8-1:0] btn_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } coin_st_e;

    localparam logic [7:0] IDLE_LVL   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] COIN_LEN_C = 8'(COIN_LEN);

    // {ext,code} -> {valid, player, button index}
    function automatic logic [4:0] decode_key(input logic [8:0] k);
        case (k)
            9'h175:  decode_key = {1'b1, 1'b0, 3'd0};
            9'h172:  decode_key = {1'b1, 1'b0, 3'd1};
            9'h16B:  decode_key = {1'b1, 1'b0, 3'd2};
            9'h174:  decode_key = {1'b1, 1'b0, 3'd3};
            9'h014:  decode_key = {1'b1, 1'b0, 3'd4};
            9'h029:  decode_key = {1'b1, 1'b0, 3'd4};
            9'h011:  decode_key = {1'b1, 1'b0, 3'd5};
            9'h005:  decode_key = {1'b1, 1'b0, 3'd6};
            9'h02E:  decode_key = {1'b1, 1'b0, 3'd7};
            9'h02D:  decode_key = {1'b1, 1'b1, 3'd0};
            9'h02B:  decode_key = {1'b1, 1'b1, 3'd1};
            9'h023:  decode_key = {1'b1, 1'b1, 3'd2};
            9'h034:  decode_key = {1'b1, 1'b1, 3'd3};
            9'h01C:  decode_key = {1'b1, 1'b1, 3'd4};
            9'h01B:  decode_key = {1'b1, 1'b1, 3'd5};
            9'h006:  decode_key = {1'b1, 1'b1, 3'd6};
            9'h036:  decode_key = {1'b1, 1'b1, 3'd7};
            default: decode_key = 5'd0;
        endcase
    endfunction

    logic                     primed_q, primed_d;
    logic                     old_toggle_q, old_toggle_d;
    logic [NPLAYERS-1:0][7:0] kbd_q, kbd_d;
    logic [4:0]               dec_s;
    logic                     event_s;
    logic                     unused_s;

    // Upper joystick bits carry no arcade function.
    assign unused_s = ^{joystick_0[15:8], joystick_1[15:8]};

    assign dec_s   = decode_key(ps2_key[8:0]);
    // The first cycle after reset only captures the toggle level, so a stale
    // toggle value is never mistaken for a fresh event.
    assign event_s = primed_q && (ps2_key[10] != old_toggle_q);

    // Keyboard event detection and key latch update
    always_comb begin
        primed_d     = 1'b1;
        old_toggle_d = ps2_key[10];
        kbd_d        = kbd_q;
        if (kbd_clear) begin
            kbd_d = '0;
        end else if (event_s && dec_s[4]) begin
            for (int p = 0; p < NPLAYERS; p++) begin
                if (dec_s[3] == 1'(p)) begin
                    kbd_d[p][dec_s[2:0]] = ps2_key[9];
                end else begin
                    kbd_d[p] = kbd_q[p];
                end
            end
        end else begin
            kbd_d = kbd_q;
        end
    end

    // Keyboard state registers
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            primed_q     <= 1'b0;
            old_toggle_q <= 1'b0;
            kbd_q        <= '0;
        end else begin
            primed_q     <= primed_d;
            old_toggle_q <= old_toggle_d;
            kbd_q        <= kbd_d;
        end
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        logic [15:0] js_s;
        logic [7:0]  joy_s;
        logic [7:0]  raw_s;
        logic [3:0]  dir_s;
        logic        creq_s;
        logic        coin_s;
        coin_st_e    state_q, state_d;
        logic [7:0]  cnt_q, cnt_d;
        logic        creq_d_q;
        logic [7:0]  btn_q, btn_d;

        if (p == 0) begin : g_js0
            assign js_s = joystick_0 | ((NPLAYERS == 1) ? joystick_1 : 16'h0000);
        end else begin : g_js1
            assign js_s = joystick_1;
        end

        // Reorder joystick R,L,D,U into the button-word U,D,L,R order.
        assign joy_s  = {js_s[7], js_s[6], js_s[5], js_s[4],
                         js_s[0], js_s[1], js_s[2], js_s[3]};
        assign raw_s  = kbd_q[p] | joy_s;
        assign creq_s = raw_s[7] | ((AUTO_COIN != 0) && raw_s[6]);
        assign coin_s = (state_q == ST_PULSE);

        // Orientation remap; dir_s is {right, left, down, up}
        always_comb begin
            dir_s = raw_s[3:0];
            case (orient)
                2'd0:    dir_s = raw_s[3:0];
                2'd1:    dir_s = {raw_s[0], raw_s[1], raw_s[3], raw_s[2]};
                2'd2:    dir_s = {raw_s[2], raw_s[3], raw_s[0], raw_s[1]};
                2'd3:    dir_s = {raw_s[1], raw_s[0], raw_s[2], raw_s[3]};
                default: dir_s = raw_s[3:0];
            endcase
        end

        // Coin pulse FSM next state; only a fresh request starts a pulse
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_IDLE: begin
                    if (creq_s && !creq_d_q) begin
                        state_d = ST_PULSE;
                        cnt_d   = COIN_LEN_C;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (ce_in) begin
                        if (cnt_q <= 8'd1) begin
                            cnt_d   = 8'd0;
                            state_d = creq_s ? ST_HOLD : ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_HOLD: begin
                    if (!creq_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        assign btn_d = {coin_s, raw_s[6:4], dir_s} ^ IDLE_LVL;

        // Coin FSM, request history and output registers
        always_ff @(posedge clk or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q  <= ST_IDLE;
                cnt_q    <= 8'd0;
                creq_d_q <= 1'b0;
                btn_q    <= IDLE_LVL;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                creq_d_q <= creq_s;
                btn_q    <= btn_d;
            end
        end

        assign btn_out[8*p +: 8] = btn_q;
    end

endmodule
